cache_stats_snapshot_l2: RTL and testbench
==========================================

# cache_stats_snapshot_L2

Snapshot sequencer downstream of the L2 cache performance controller. On a start request it freezes the controller's event counters. It walks the controller's 5-bit statistics index space and captures each registered 32-bit return word into a 19-entry snapshot buffer. It then re-enables counting. The host reads a coherent image of all L2 statistics: lo/hi halves consistent, all counters taken at the same cycle.

## Interface
- N_WORDS, 19: snapshot buffer depth; fixed index table below.
- clock_i  in  1  single clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  snapshot request; sampled only in IDLE.
- count_en_i  in  1  host counting enable; passed to controller when not busy.
- sel_i  in  2  host data-record select; passed through when not busy.
- stats_i  in  32  controller return word (registered there, 1-edge latency from index).
- comm_o  out  32  controller config word: {7'b0, count_en, 19'b0, index[4:0]}.
- select_o  out  2  controller data-record select.
- rd_addr_i  in  5  snapshot buffer read address, 0..18.
- rd_data_o  out  32  registered read data.
- busy_o  out  1  high while snapshot in progress.
- done_o  out  1  one-cycle pulse at completion.
- snapshot_valid_o  out  1  buffer holds a complete snapshot.

## Operation
- Index table, slot→controller index: 0-1→0,1 (hit); 2-3→2,3 (miss); 4-5→4,5 (writeback); 6-7→6,7 (walltime); 8-9→8,9 (expired); 10-11→10,11 (defaulted); 12-13→12,13 (multi-expired); 14-15→16,17 (default misses); 16-17→18,19 (random evict); 18→15 (cache id).
- count_en (comm_o[24]) is a register: busy ? 0 : count_en_i. select_o is busy ? 2'b00 : sel_i, combinational.
- States:
  - IDLE: start_i=1 → FREEZE. Set busy_o, clear snapshot_valid_o, drive count_en 0.
  - FREEZE, 1 cycle: counters settle → ISSUE. Load index register with table[0].
  - ISSUE, 19 cycles: the slot counter i advances 0→18. The index register takes table[i] each cycle. After i=18 → DRAIN.
  - DRAIN, 2 cycles: flush the capture pipe → DONE.
  - DONE, 1 cycle: done_o=1, snapshot_valid_o=1, busy_o cleared, count_en restored → IDLE.
- Capture pipe: the slot number is delayed 2 edges alongside the index. On edge (issue edge + 2) the block writes stats_i into buffer[slot].
- Read port: rd_data_o <= buffer[rd_addr_i] every edge, independent of state. rd_addr_i > 18 returns 0. Reads during busy return partially updated contents; snapshot_valid_o=0 flags this.
- comm_o[4:0] in IDLE holds the last index issued. All other comm_o bits are 0.

## Timing
- Let E0 be the edge that samples start_i=1 in IDLE.
- busy_o=1 and count_en=0 take effect after E0.
- First index is issued at E0+1. Index k is issued at E0+1+k. Slot k is captured at E0+3+k. The last capture is at E0+21.
- done_o=1 for exactly the cycle after E0+23. busy_o=0, snapshot_valid_o=1 and count_en=count_en_i take effect after E0+23. Snapshot latency is 23 cycles.
- start_i while busy is ignored; no queueing. start_i held high re-triggers at the first IDLE edge after DONE.
- count_en_i changing while busy has no effect until DONE.
- Reset values: state IDLE, busy_o=0, done_o=0, snapshot_valid_o=0, comm_o=0, rd_data_o=0, buffer all 0.
- Reset mid-snapshot: the next cycle is IDLE with the reset values. The buffer is cleared and done_o is not asserted.

## Test plan
- Basic snapshot: the controller model returns word = 0xA000_0000|index. Assert start.
  - busy for cycles E0+1..E0+23 and done at E0+24.
  - buffer[14]=0xA000_0010, buffer[18]=0xA000_000F.
- Freeze coherency: the model increments the hit counter every cycle while comm_o[24]=1, starting from 0x0000_0000_FFFF_FFF0, with count_en_i=1.
  - comm_o[24]=0 from E0+1 to E0+23.
  - The captured hi/lo pair is a single consistent 64-bit value.
  - Counting resumes at E0+24.
- Start during busy: pulse start at E0+5 and E0+23 → exactly one done pulse. A second snapshot begins only when start is sampled in IDLE.
- Reset at E0+10: reset_i high for 1 cycle.
  - busy_o=0, snapshot_valid_o=0, buffer[0]=0, no done_o.
  - A fresh start then completes normally.
- Passthrough: when idle, sel_i=2'b11 and count_en_i=0 → select_o=2'b11 and comm_o[24]=0. During busy, select_o=2'b00.
- Read port: rd_addr_i=19..31 → rd_data_o=0. rd_addr_i=6 → walltime lo word one edge later.

Source files
------------

// File: rtl/cache_stats_snapshot_l2.sv
// Snapshot sequencer for the L2 performance controller: freezes the counters,
// walks the statistics index table into a 19-word buffer, then re-enables counting.
module cache_stats_snapshot_l2 (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        count_en_i,
  input  logic [1:0]  sel_i,
  input  logic [31:0] stats_i,
  output logic [31:0] comm_o,
  output logic [1:0]  select_o,
  input  logic [4:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        snapshot_valid_o,
  output logic [2:0]  state_o
);

  localparam int         N_WORDS   = 19;
  localparam logic [4:0] LAST_SLOT = 5'd18;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FREEZE = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [4:0]  slot;
  logic        drain_cnt;
  logic [4:0]  index;
  logic        count_en;
  logic        issue_a;
  logic        issue_b;
  logic [4:0]  slot_b;
  logic        done;
  logic        valid;
  logic [31:0] rd_data;
  logic [31:0] buffer [0:N_WORDS-1];

  // Slots 14..17 skip controller index 14/15; slot 18 picks up the cache id at 15.
  function automatic logic [4:0] slot_index(input logic [4:0] s);
    if (s >= 5'd14 && s <= 5'd17) return s + 5'd2;
    else if (s == LAST_SLOT)      return 5'd15;
    else                          return s;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = S_FREEZE;
      S_FREEZE: state_nxt = S_ISSUE;
      S_ISSUE:  if (slot == LAST_SLOT) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_cnt) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state     <= S_IDLE;
      slot      <= '0;
      drain_cnt <= 1'b0;
      index     <= '0;
      count_en  <= 1'b0;
      issue_a   <= 1'b0;
      issue_b   <= 1'b0;
      slot_b    <= '0;
      done      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Counting is held off from the start edge until the DONE edge.
      count_en <= (state_nxt == S_IDLE) ? count_en_i : 1'b0;
      done     <= (state == S_DONE);
      // Second stage of the capture pipe: the controller registers its
      // return word one edge after the index, we capture one edge later.
      issue_b  <= issue_a;
      slot_b   <= slot;
      issue_a  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) valid <= 1'b0;
        end
        S_FREEZE: begin
          slot    <= '0;
          index   <= slot_index(5'd0);
          issue_a <= 1'b1;
        end
        S_ISSUE: begin
          if (slot != LAST_SLOT) begin
            slot    <= slot + 5'd1;
            index   <= slot_index(slot + 5'd1);
            issue_a <= 1'b1;
          end
        end
        S_DRAIN: begin
          drain_cnt <= ~drain_cnt;
        end
        S_DONE: begin
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int k = 0; k < N_WORDS; k++) buffer[k] <= '0;
      rd_data <= '0;
    end else begin
      if (issue_b) buffer[slot_b] <= stats_i;
      rd_data <= (rd_addr_i <= LAST_SLOT) ? buffer[rd_addr_i] : '0;
    end
  end

  assign busy_o           = (state != S_IDLE);
  assign done_o           = done;
  assign snapshot_valid_o = valid;
  assign rd_data_o        = rd_data;
  assign comm_o           = {7'b0, count_en, 19'b0, index};
  assign select_o         = busy_o ? 2'b00 : sel_i;
  assign state_o          = state;

endmodule

// File: tb/tb_cache_stats_snapshot_l2.sv
// Bench for cache_stats_snapshot_l2 with a behavioural L2 controller model:
// counters that advance only while counting is enabled, returned one edge after the index.
module tb_cache_stats_snapshot_l2;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic        count_en_i;
  logic [1:0]  sel_i;
  logic [31:0] stats_i;
  logic [31:0] comm_o;
  logic [1:0]  select_o;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic        busy_o;
  logic        done_o;
  logic        snapshot_valid_o;
  logic [2:0]  state_o;

  always #5 clock_i = ~clock_i;

  cache_stats_snapshot_l2 dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .count_en_i(count_en_i), .sel_i(sel_i), .stats_i(stats_i),
    .comm_o(comm_o), .select_o(select_o), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .busy_o(busy_o), .done_o(done_o),
    .snapshot_valid_o(snapshot_valid_o), .state_o(state_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Slot -> controller index map of the statistics layout.
  int slot_idx [19] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 16, 17, 18, 19, 15};

  // Controller model: 64-bit hit counter at indices 0/1, other indices in regs.
  logic [63:0] hit;
  logic [31:0] regs [32];
  bit          churn;
  logic [31:0] exp_snap [19];
  logic [63:0] hit_frozen;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] word_of(input int idx);
    if (idx == 0) return hit[31:0];
    if (idx == 1) return hit[63:32];
    return regs[idx];
  endfunction

  always @(posedge clock_i) begin
    if (comm_o[24]) begin
      hit <= hit + 64'd1;
      if (churn) for (int j = 2; j < 32; j++) regs[j] <= $urandom;
    end
    stats_i <= word_of(int'(comm_o[4:0]));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one snapshot from the start edge E0 for 31 cycles; extra start
  // pulses are sampled at edges E0+p1 / E0+p2 (0 = none).
  task automatic do_snapshot(input bit cen, input int p1, input int p2);
    logic [1:0] s;
    count_en_i = cen;
    start_i    = 1'b1;
    @(posedge clock_i);
    for (int n = 0; n <= 30; n++) begin
      @(negedge clock_i);
      start_i = ((n + 1) == p1) || ((n + 1) == p2);
      s = 2'($urandom_range(0, 3));
      sel_i = s;
      #1;
      check("busy", busy_o, n < 23);
      check("done", done_o, n == 23);
      check("valid", snapshot_valid_o, n >= 23);
      check("count_en", comm_o[24], (n < 23) ? 1'b0 : cen);
      check("select", select_o, (n < 23) ? 2'b00 : s);
      if (n == 23) begin
        for (int k = 0; k < 19; k++) exp_snap[k] = word_of(slot_idx[k]);
        hit_frozen = hit;
      end
      if (n == 24 && cen) check("resume", hit[31:0], hit_frozen[31:0] + 32'd1);
    end
    start_i = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < 19; k++) exp_q.push_back(exp_snap[k]);
    for (int k = 0; k < 19; k++) begin
      rd_addr_i = 5'(k);
      @(negedge clock_i);
      check(tag, rd_data_o, exp_q.pop_front());
    end
  endtask

  task automatic read_word(input logic [4:0] a, output logic [31:0] d);
    rd_addr_i = a;
    @(negedge clock_i);
    d = rd_data_o;
  endtask

  task automatic reset_mid();
    count_en_i = 1'b1;
    start_i    = 1'b1;
    @(posedge clock_i);
    for (int n = 0; n <= 30; n++) begin
      @(negedge clock_i);
      start_i = 1'b0;
      if (n >= 10) begin
        check("rst_busy", busy_o, 1'b0);
        check("rst_valid", snapshot_valid_o, 1'b0);
      end
      if (n == 10) check("rst_comm", comm_o, 32'h0);
      check("rst_done", done_o, 1'b0);
      reset_i = (n == 9);
    end
  endtask

  initial begin
    logic [31:0] d;
    reset_i = 1'b1; start_i = 1'b0; count_en_i = 1'b0; sel_i = 2'b00;
    rd_addr_i = '0; churn = 1'b0; hit = '0;
    for (int j = 0; j < 32; j++) regs[j] = '0;
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    check("reset_busy", busy_o, 1'b0);
    check("reset_done", done_o, 1'b0);
    check("reset_valid", snapshot_valid_o, 1'b0);
    check("reset_comm", comm_o, 32'h0);
    check("reset_rd", rd_data_o, 32'h0);

    // Idle passthrough
    sel_i = 2'b11; count_en_i = 1'b0;
    @(negedge clock_i);
    check("pass_sel", select_o, 2'b11);
    check("pass_cen0", comm_o[24], 1'b0);
    count_en_i = 1'b1;
    @(negedge clock_i);
    check("pass_cen1", comm_o[24], 1'b1);

    // Basic snapshot with index-tagged words
    count_en_i = 1'b0;
    repeat (2) @(negedge clock_i);
    hit = {32'hA000_0001, 32'hA000_0000};
    for (int j = 2; j < 32; j++) regs[j] = 32'hA000_0000 | 32'(j);
    do_snapshot(1'b0, 0, 0);
    check("idle_comm", comm_o, 32'h0000_000F);
    read_all("basic_buf");
    read_word(5'd14, d); check("basic_buf14", d, 32'hA000_0010);
    read_word(5'd18, d); check("basic_buf18", d, 32'hA000_000F);

    // Freeze coherency across the low-word carry
    hit = 64'h0000_0000_FFFF_FFF0;
    count_en_i = 1'b1;
    repeat ($urandom_range(5, 25)) @(negedge clock_i);
    do_snapshot(1'b1, 0, 0);
    read_all("coherent_buf");
    check("coherent_lo", exp_snap[0], hit_frozen[31:0]);
    check("coherent_hi", exp_snap[1], hit_frozen[63:32]);

    // Start pulses while busy are ignored
    do_snapshot(1'($urandom_range(0, 1)), 5, 23);
    read_all("busy_start_buf");

    // Reset in the middle of a snapshot
    hit = 64'h1234_5678_9ABC_DEF0;
    reset_mid();
    read_word(5'd0, d); check("rst_buf0", d, 32'h0);
    do_snapshot(1'b1, 0, 0);
    read_all("post_rst_buf");

    // Randomized rounds with churning counters
    churn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      hit = {$urandom, $urandom};
      count_en_i = 1'b1;
      repeat ($urandom_range(2, 20)) @(negedge clock_i);
      do_snapshot(1'($urandom_range(0, 1)), 0, 0);
      read_all("rand_buf");
    end

    // Read port range
    for (int a = 19; a < 32; a++) begin
      read_word(5'(a), d);
      check("rd_oob", d, 32'h0);
    end
    read_word(5'd6, d); check("rd_walltime_lo", d, exp_snap[6]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
